// File: rtl/ll8_to_fifo36.sv
// Packs an active-low 8-bit LocalLink byte stream into 36-bit FIFO words
// ({occ, eof, sof, byte0..byte3}), sustaining one byte per clock.
module ll8_to_fifo36 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  ll_data,
    input  logic        ll_sof_n,
    input  logic        ll_eof_n,
    input  logic        ll_src_rdy_n,
    output logic        ll_dst_rdy_n,
    output logic [35:0] f36_data,
    output logic        f36_src_rdy_o,
    input  logic        f36_dst_rdy_i,
    output logic [3:0]  debug
);

    typedef enum logic [2:0] {
        StEmpty = 3'd0,
        StLane1 = 3'd1,
        StLane2 = 3'd2,
        StLane3 = 3'd3,
        StHold  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [35:0] data_q, data_d;
    logic        hold;
    logic        ll_accept;
    logic        lane_wr;
    logic [1:0]  lane;
    logic [1:0]  lane_inc;

    assign hold          = (state_q == StHold);
    assign f36_src_rdy_o = hold;
    // Pass downstream ready straight through so a word leaves and a byte enters on one cycle
    assign ll_dst_rdy_n  = hold ? ~f36_dst_rdy_i : 1'b0;
    assign ll_accept     = ~ll_src_rdy_n & ~ll_dst_rdy_n;
    assign f36_data      = data_q;
    assign debug         = {ll_accept, state_q};
    assign lane_inc      = lane + 2'd1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        lane_wr = 1'b0;
        lane    = 2'd0;

        unique case (state_q)
            StEmpty, StLane1, StLane2, StLane3: begin
                if (ll_accept) begin
                    lane_wr = 1'b1;
                    lane    = state_q[1:0];
                end
            end
            StHold: begin
                if (f36_dst_rdy_i) begin
                    state_d = StEmpty;
                    if (ll_accept) begin
                        lane_wr = 1'b1;
                        lane    = 2'd0;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase

        if (lane_wr) begin
            if (lane == 2'd0) begin
                data_d[33]   = 1'b0;
                data_d[32]   = ~ll_sof_n;
                data_d[23:0] = 24'h0;
            end
            unique case (lane)
                2'd0: data_d[31:24] = ll_data;
                2'd1: data_d[23:16] = ll_data;
                2'd2: data_d[15:8]  = ll_data;
                2'd3: data_d[7:0]   = ll_data;
                default: ;
            endcase
            if (!ll_eof_n || lane == 2'd3) begin
                // occ wraps to 0 for a full word
                data_d[35:34] = lane_inc;
                data_d[33]    = ~ll_eof_n;
                state_d       = StHold;
            end else begin
                state_d = state_t'({1'b0, lane_inc});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= StEmpty;
            data_q  <= 36'h0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_ll8_to_fifo36.sv
// Self-checking bench for ll8_to_fifo36: directed frames plus randomized
// gaps checked every cycle against a byte-queue packing model.
module tb_ll8_to_fifo36;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic [7:0]  ll_data;
    logic        ll_sof_n, ll_eof_n, ll_src_rdy_n;
    logic        ll_dst_rdy_n;
    logic [35:0] f36_data;
    logic        f36_src_rdy_o;
    logic        f36_dst_rdy_i;
    logic [3:0]  debug;

    always #5 clk = ~clk;

    ll8_to_fifo36 dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .ll_data       (ll_data),
        .ll_sof_n      (ll_sof_n),
        .ll_eof_n      (ll_eof_n),
        .ll_src_rdy_n  (ll_src_rdy_n),
        .ll_dst_rdy_n  (ll_dst_rdy_n),
        .f36_data      (f36_data),
        .f36_src_rdy_o (f36_src_rdy_o),
        .f36_dst_rdy_i (f36_dst_rdy_i),
        .debug         (debug)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          ds_random = 1'b0;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    int          got_cyc[$];
    logic [7:0]  cur [4];
    int          cur_n = 0;
    logic        cur_sof = 1'b0;

    task check_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference packer: collect accepted bytes, emit a word at eof or after four bytes.
    task model_byte(input logic [7:0] b, input logic sof, input logic eof);
        logic [1:0] occ;
        if (cur_n == 0) begin
            cur_sof = sof;
            for (int i = 0; i < 4; i++) cur[i] = 8'h0;
        end
        cur[cur_n] = b;
        cur_n++;
        if (eof || cur_n == 4) begin
            occ = 2'(cur_n % 4);
            exp_q.push_back({occ, eof, cur_sof, cur[0], cur[1], cur[2], cur[3]});
            cur_n = 0;
        end
    endtask

    always @(negedge clk) begin
        logic exp_valid, exp_dst_n, acc;
        cyc++;
        if (reset || clear) begin
            exp_q.delete();
            cur_n = 0;
        end else begin
            exp_valid = (exp_q.size() > 0);
            exp_dst_n = exp_valid ? !f36_dst_rdy_i : 1'b0;
            acc       = !ll_src_rdy_n && !exp_dst_n;
            check_eq("src_rdy", 36'(f36_src_rdy_o), 36'(exp_valid));
            check_eq("dst_rdy_n", 36'(ll_dst_rdy_n), 36'(exp_dst_n));
            check_eq("debug", 36'(debug), 36'({acc, exp_valid ? 3'd4 : 3'(cur_n)}));
            if (exp_valid) check_eq("word", f36_data, exp_q[0]);
            if (exp_valid && f36_dst_rdy_i) begin
                got_q.push_back(f36_data);
                got_cyc.push_back(cyc);
                void'(exp_q.pop_front());
            end
            if (acc) model_byte(ll_data, !ll_sof_n, !ll_eof_n);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ds_random) f36_dst_rdy_i = ($urandom_range(99) < 65);
        end
    end

    task idle(input int n);
        ll_src_rdy_n = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task drive_byte(input logic [7:0] b, input logic sof, input logic eof, input int gap_pct);
        int waited;
        while ($urandom_range(99) < gap_pct) begin
            ll_src_rdy_n = 1'b1;
            @(posedge clk);
            #1;
        end
        ll_data      = b;
        ll_sof_n     = !sof;
        ll_eof_n     = !eof;
        ll_src_rdy_n = 1'b0;
        waited = 0;
        forever begin
            @(negedge clk);
            if (!ll_dst_rdy_n || waited > 200) break;
            waited++;
        end
        check_eq("accept_wait_bound", 36'(waited > 200), 36'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        reset         = 1'b1;
        clear         = 1'b0;
        ll_data       = 8'h0;
        ll_sof_n      = 1'b1;
        ll_eof_n      = 1'b1;
        ll_src_rdy_n  = 1'b1;
        f36_dst_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_data", f36_data, 36'h0);
        check_eq("reset_state", 36'(debug[2:0]), 36'd0);
        @(posedge clk);
        #1;

        // Eight-byte frame
        got_q.delete();
        got_cyc.delete();
        for (int i = 1; i <= 8; i++) drive_byte(8'(i), i == 1, i == 8, 0);
        idle(3);
        check_eq("f8_count", 36'(got_q.size()), 36'd2);
        if (got_q.size() == 2) begin
            check_eq("f8_w0", got_q[0], 36'h1_01020304);
            check_eq("f8_w1", got_q[1], 36'h2_05060708);
            check_eq("f8_spacing", 36'(got_cyc[1] - got_cyc[0]), 36'd4);
        end

        // Short frames
        got_q.delete();
        drive_byte(8'hAA, 1, 1, 0);
        idle(2);
        drive_byte(8'hAA, 1, 0, 0);
        drive_byte(8'hBB, 0, 1, 0);
        idle(2);
        drive_byte(8'hAA, 1, 0, 0);
        drive_byte(8'hBB, 0, 0, 0);
        drive_byte(8'hCC, 0, 1, 0);
        idle(3);
        check_eq("short_count", 36'(got_q.size()), 36'd3);
        if (got_q.size() == 3) begin
            check_eq("short1", got_q[0], 36'h7_AA000000);
            check_eq("short2", got_q[1], 36'hB_AABB0000);
            check_eq("short3", got_q[2], 36'hF_AABBCC00);
        end

        // Backpressure with a pending upstream byte
        got_q.delete();
        f36_dst_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) drive_byte(8'hC1 + 8'(i), 0, 0, 0);
        ll_data      = 8'hC5;
        ll_sof_n     = 1'b1;
        ll_eof_n     = 1'b0;
        ll_src_rdy_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_dst_rdy_n", 36'(ll_dst_rdy_n), 36'd1);
            check_eq("bp_data", f36_data, 36'h0_C1C2C3C4);
            @(posedge clk);
            #1;
        end
        f36_dst_rdy_i = 1'b1;
        @(negedge clk);
        check_eq("bp_release_accept", 36'(debug[3]), 36'd1);
        @(posedge clk);
        #1;
        ll_src_rdy_n = 1'b1;
        @(negedge clk);
        check_eq("bp_next_word", f36_data, 36'h6_C5000000);
        @(posedge clk);
        #1;
        idle(2);
        check_eq("bp_count", 36'(got_q.size()), 36'd2);
        if (got_q.size() == 2) check_eq("bp_w0", got_q[0], 36'h0_C1C2C3C4);

        // Back-to-back single-byte frames
        got_q.delete();
        got_cyc.delete();
        drive_byte(8'h11, 1, 1, 0);
        drive_byte(8'h22, 1, 1, 0);
        drive_byte(8'h33, 1, 1, 0);
        idle(3);
        check_eq("b2b_count", 36'(got_q.size()), 36'd3);
        if (got_q.size() == 3) begin
            check_eq("b2b_w0", got_q[0], 36'h7_11000000);
            check_eq("b2b_w1", got_q[1], 36'h7_22000000);
            check_eq("b2b_w2", got_q[2], 36'h7_33000000);
            check_eq("b2b_span", 36'(got_cyc[2] - got_cyc[0]), 36'd2);
        end

        // Clear mid-frame
        got_q.delete();
        drive_byte(8'h77, 1, 0, 0);
        drive_byte(8'h78, 0, 0, 0);
        ll_src_rdy_n = 1'b1;
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check_eq("clear_data", f36_data, 36'h0);
        check_eq("clear_state", 36'(debug[2:0]), 36'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_byte(8'h5A + 8'(i), i == 0, 0, 0);
        idle(3);
        check_eq("clear_count", 36'(got_q.size()), 36'd1);
        if (got_q.size() == 1) check_eq("clear_w0", got_q[0], 36'h1_5A5B5C5D);

        // Random frames with gaps on both sides
        ds_random = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            bit has_eof;
            len     = $urandom_range(12, 1);
            has_eof = ($urandom_range(9) != 0);
            for (int i = 0; i < len; i++) begin
                drive_byte(8'($urandom), (i == 0) || ($urandom_range(19) == 0),
                           has_eof && (i == len - 1), 30);
            end
        end
        drive_byte(8'hEE, 1, 1, 30);
        ll_src_rdy_n = 1'b1;
        ds_random    = 1'b0;
        @(posedge clk);
        #2;
        f36_dst_rdy_i = 1'b1;
        idle(5);
        check_eq("drain_empty", 36'(exp_q.size()), 36'd0);
        check_eq("drain_partial", 36'(cur_n), 36'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
